// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART state encoding and default frame constants.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    // Defaults shared with the baud generator and transmitter.
    localparam int c_DATA_BITS_DEF  = 8;
    localparam int c_OVERSAMPLE_DEF = 8;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Two-flop synchronizer for a single asynchronous input bit.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : Oversampling UART receiver, majority-vote bit recovery,
//             one-cycle valid / frame_err strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = c_DATA_BITS_DEF,
    parameter int OVERSAMPLE = c_OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_MID    = OVERSAMPLE / 2;
    localparam int c_TICK_W = clog2_min1(OVERSAMPLE);
    localparam int c_BIT_W  = clog2_min1(DATA_BITS);

    localparam logic [c_TICK_W-1:0] c_T_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_T_S0   = c_TICK_W'(c_MID - 1);
    localparam logic [c_TICK_W-1:0] c_T_S1   = c_TICK_W'(c_MID);
    localparam logic [c_TICK_W-1:0] c_T_S2   = c_TICK_W'(c_MID + 1);
    localparam logic [c_BIT_W-1:0]  c_B_LAST = c_BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_TICK_W-1:0]  w_tick_nxt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_BIT_W-1:0]   w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic [2:0]           r_samp;
    logic [2:0]           w_samp_nxt;
    logic                 w_vote;
    logic                 w_valid_nxt;
    logic                 w_ferr_nxt;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // The vote includes the sample taken on the current tick, so the stop
    // bit can be decided on the very tick of its last sample.
    always_comb begin
        w_samp_nxt = r_samp;
        if (r_tick_cnt == c_T_S0) w_samp_nxt[0] = w_rx_s;
        if (r_tick_cnt == c_T_S1) w_samp_nxt[1] = w_rx_s;
        if (r_tick_cnt == c_T_S2) w_samp_nxt[2] = w_rx_s;
        w_vote = (w_samp_nxt[0] & w_samp_nxt[1]) |
                 (w_samp_nxt[0] & w_samp_nxt[2]) |
                 (w_samp_nxt[1] & w_samp_nxt[2]);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        if (rx_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = ST_START;
                        w_tick_nxt  = '0;
                    end
                end
                ST_START: begin
                    if (r_tick_cnt == c_T_LAST) begin
                        w_tick_nxt = '0;
                        if (w_vote) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DATA;
                            w_bit_nxt   = '0;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_tick_cnt == c_T_LAST) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_B_LAST) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Decided half a bit early so the next start edge is not missed.
                    if (r_tick_cnt == c_T_S2) begin
                        w_tick_nxt = '0;
                        if (w_vote) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = ST_WAIT_HIGH;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_rx_s) w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tick_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_samp     <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            data       <= w_data_nxt;
            valid      <= w_valid_nxt;
            frame_err  <= w_ferr_nxt;
            busy       <= (w_state_nxt != ST_IDLE);
            if (rx_tick) r_samp <= w_samp_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Self-checking bench for uart_rx with a strobe scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_OVS      = 8;
    localparam int c_TICK_DIV = 10;
    localparam int c_BIT_CLKS = c_OVS * c_TICK_DIV;
    localparam int c_NVEC     = 8;

    typedef struct {
        logic [7:0] byte_in;
        logic       stop_bit;
        int         glitch_bit;
        int         gap_bits;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_tick;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    sb_t        sb[$];
    vec_t       vecs[c_NVEC];
    logic [7:0] prev_data = 8'h00;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (c_OVS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_tick   (rx_tick),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        rx_tick = 1'b0;
        forever begin
            repeat (c_TICK_DIV - 1) @(negedge clk);
            rx_tick = 1'b1;
            @(negedge clk);
            rx_tick = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic line(input logic v, input int n_clks);
        rx = v;
        repeat (n_clks) @(negedge clk);
    endtask

    task automatic push(input logic is_err, input logic [7:0] d);
        sb_t e;
        e.is_err = is_err;
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
        line(1'b0, c_BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                line(b[i], c_BIT_CLKS / 2);
                line(~b[i], c_TICK_DIV);
                line(b[i], c_BIT_CLKS / 2 - c_TICK_DIV);
            end else begin
                line(b[i], c_BIT_CLKS);
            end
        end
        line(stop, c_BIT_CLKS);
    endtask

    // Strobe monitor: every valid/frame_err must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            prev_data = 8'h00;
        end else begin
            if (valid || frame_err) begin
                chk("strobe_exclusive", {31'd0, valid & frame_err}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=0x%0h", valid, frame_err, data);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    if (!e.is_err) begin
                        chk("rx_data", {24'd0, data}, {24'd0, e.data});
                        chk("busy_at_valid", {31'd0, busy}, 32'd0);
                    end else begin
                        chk("busy_at_ferr", {31'd0, busy}, 32'd1);
                    end
                end
            end
            if (data !== prev_data) chk("data_hold", {31'd0, valid}, 32'd1);
            prev_data = data;
        end
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, -1, 2, 1'b0, 8'h55};
        vecs[1] = '{8'h00, 1'b1, -1, 1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, -1, 1, 1'b0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1,  2, 1, 1'b0, 8'h3C};
        vecs[4] = '{8'hA3, 1'b1, -1, 0, 1'b0, 8'hA3};
        vecs[5] = '{8'h0F, 1'b1, -1, 2, 1'b0, 8'h0F};
        vecs[6] = '{8'h96, 1'b1,  0, 1, 1'b0, 8'h96};
        vecs[7] = '{8'h01, 1'b1,  7, 2, 1'b0, 8'h01};

        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data",  {24'd0, data},      32'd0);
        chk("reset_valid", {31'd0, valid},     32'd0);
        chk("reset_ferr",  {31'd0, frame_err}, 32'd0);
        chk("reset_busy",  {31'd0, busy},      32'd0);
        rst = 1'b1;
        line(1'b1, 2 * c_BIT_CLKS);

        for (int v = 0; v < c_NVEC; v++) begin
            push(vecs[v].exp_err, vecs[v].exp_data);
            send_frame(vecs[v].byte_in, vecs[v].stop_bit, vecs[v].glitch_bit);
            line(1'b1, vecs[v].gap_bits * c_BIT_CLKS);
        end

        // False start: two tick periods low must not produce any strobe.
        line(1'b0, 2 * c_TICK_DIV);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        line(1'b1, 12 * c_TICK_DIV);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        line(1'b1, c_BIT_CLKS);

        // Framing error followed by a held-low break, then a good frame.
        push(1'b1, 8'h00);
        send_frame(8'h81, 1'b0, -1);
        line(1'b0, c_BIT_CLKS);
        chk("break_busy", {31'd0, busy}, 32'd1);
        line(1'b0, 2 * c_BIT_CLKS);
        line(1'b1, 2 * c_BIT_CLKS);
        chk("break_idle", {31'd0, busy}, 32'd0);
        push(1'b0, 8'h7E);
        send_frame(8'h7E, 1'b1, -1);
        line(1'b1, 2 * c_BIT_CLKS);

        // Reset during bit 4 of a frame aborts it silently.
        line(1'b0, c_BIT_CLKS);
        for (int i = 0; i < 4; i++) line(i[0], c_BIT_CLKS);
        line(1'b1, c_BIT_CLKS / 2);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        chk("abort_data",  {24'd0, data},      32'd0);
        chk("abort_valid", {31'd0, valid},     32'd0);
        chk("abort_ferr",  {31'd0, frame_err}, 32'd0);
        chk("abort_busy",  {31'd0, busy},      32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        line(1'b1, 2 * c_BIT_CLKS);
        push(1'b0, 8'hC6);
        send_frame(8'hC6, 1'b1, -1);
        line(1'b1, 2 * c_BIT_CLKS);

        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver that consumes the oversampled receive tick produced by the baud generator. It recovers 8N1-style frames from the asynchronous rx line and delivers each byte with a one-cycle valid strobe. Framing errors are flagged separately. Operates entirely in the system clock domain; the tick is an enable, never a clock.

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first
OVERSAMPLE, 8, rx_tick pulses per bit period; must be even and >= 4; must match baud generator OVERSAMPLE_TIME

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
rx_tick  input  1  one-clk-wide enable pulse at BAUD*OVERSAMPLE, from baud generator rx_clk
rx  input  1  asynchronous serial line, idle high
data  output  DATA_BITS  last correctly framed byte
valid  output  1  one-cycle strobe: data updated
frame_err  output  1  one-cycle strobe: stop bit sampled low
busy  output  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, tick_cnt=0, bit_cnt=0, shift=0, data=0, valid=0, frame_err=0, busy=0; synchronizer flops preset to 1.
- rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
- All state/counter updates occur only on clk edges where rx_tick=1; with rx_tick=0 everything holds, strobes clear.
- MID = OVERSAMPLE/2. Within each bit, tick_cnt runs 0..OVERSAMPLE-1; samples taken at tick_cnt = MID-1, MID, MID+1; bit value = majority of the 3 samples.
- States:
  IDLE: on tick with rx_s=0 -> START, tick_cnt=0.
  START: at tick_cnt=OVERSAMPLE-1: if vote=1 (false start) -> IDLE; else -> DATA, bit_cnt=0, tick_cnt=0.
  DATA: at tick_cnt=OVERSAMPLE-1: shift vote in at MSB (shift right, so first bit lands at LSB); if bit_cnt=DATA_BITS-1 -> STOP, else bit_cnt+1; tick_cnt=0.
  STOP: decided at tick_cnt=MID+1 (half-bit early, allows resync to the next start edge): vote=1 -> data<=shift, valid=1, -> IDLE; vote=0 -> frame_err=1, data unchanged, -> WAIT_HIGH.
  WAIT_HIGH: on tick with rx_s=1 -> IDLE (prevents a held-low line/break from retriggering frames).
- valid and frame_err are registered, high exactly one clk cycle, on the edge consuming the deciding tick; never both high.
- data holds between frames; changes only with valid.
- busy = (state != IDLE), registered.
- Back-to-back frames: a start edge arriving on the tick after the STOP decision is accepted.
- Reset mid-frame aborts silently: no valid, no frame_err.
- Latency: valid rises 2 clk (synchronizer) + (1 + DATA_BITS)*OVERSAMPLE + MID+2 ticks after the falling start edge.

Decomposition:
- Shared package uart_pkg: state encoding (IDLE, START, DATA, STOP, WAIT_HIGH, 3 bits), default DATA_BITS/OVERSAMPLE constants shared with baud generator and transmitter.
- One sub-module: sync_2ff (2-flop synchronizer, reset value parameter = 1), reusable by other async inputs.

Test Plan:
- 100 MHz clk, rx_tick from baud generator (115200, x8); drive byte 0x55 with stop=1 -> single valid pulse, data=0x55, frame_err never high, busy falls with valid.
- 0xA3 immediately followed by 0x0F (no idle gap) -> two valid pulses, data 0xA3 then 0x0F.
- rx low glitch lasting 2 tick periods then high -> START vote=1, returns to IDLE, no valid, no frame_err.
- 0x3C with rx forced opposite for 1 tick period at MID in bit 2 -> majority rejects glitch, data=0x3C.
- 0x81 with stop bit=0, line held low for 3 more bit times, then high, then 0x7E -> exactly one frame_err pulse, no valid for first frame, then valid with data=0x7E.
- rst pulled low during bit 4 of a frame, released, then 0xC6 sent -> outputs reset to 0 immediately, no strobe from aborted frame, next valid with data=0xC6.
